jtsbaskt_romarb: RTL and testbench

Four-way ROM request arbiter that shares one downstream ROM/SDRAM read port between the main CPU, sound CPU, PCM sample fetch and scroll graphics fetch of the Super Basketball core. Each requester gets a one-entry cache (tag + data) that keeps its `ok` asserted while its address is unchanged, so repeated reads do not reach the shared port. The block sits between the game top level and the ROM download/SDRAM controller, in the 24 MHz CPU clock domain.

---
 rtl/jtsbaskt_romarb.sv | 124 ++++++++++++
 tb/tb_jtsbaskt_romarb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtsbaskt_romarb.sv
// Four-way ROM request arbiter with a one-entry tag/data cache per requester.
// Define JTSBASKT_RR_EN for round-robin arbitration; otherwise fixed priority main > sound > PCM > scroll.
module jtsbaskt_romarb #(
  parameter int AW = 22,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req_cs,
  input  logic [4*AW-1:0] req_addr,
  output logic [4*DW-1:0] req_data,
  output logic [3:0]      req_ok,
  output logic            rom_cs,
  output logic [AW-1:0]   rom_addr,
  input  logic [DW-1:0]   rom_data,
  input  logic            rom_ok
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           r_win;
  logic [3:0]           r_valid;
  logic [3:0][AW-1:0]   r_tag;
  logic [3:0][DW-1:0]   r_data;
  logic [3:0]           w_hit;
  logic [3:0]           w_miss;
  logic [1:0]           w_sel;
  logic                 w_any;

  // Tag compare per requester
  always_comb begin
    w_hit = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_hit[i] = r_valid[i] && (r_tag[i] == req_addr[i*AW +: AW]);
    end
  end

  assign req_ok   = req_cs & w_hit;
  assign w_miss   = req_cs & ~w_hit;
  assign req_data = r_data;

`ifdef JTSBASKT_RR_EN
  logic [1:0] r_ptr;
  logic [1:0] w_idx;

  // Round-robin pick: descending scan so the slot right after r_ptr wins
  always_comb begin
    w_sel = 2'd0;
    w_idx = 2'd0;
    w_any = |w_miss;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_ptr + 2'(k);
      w_sel = w_miss[w_idx] ? w_idx : w_sel;
    end
  end

  // Pointer tracks the most recent grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd3;
    end else if (r_state == ST_IDLE && w_any) begin
      r_ptr <= w_sel;
    end else begin
      r_ptr <= r_ptr;
    end
  end
`else
  // Fixed-priority pick: lowest index wins
  always_comb begin
    w_sel = 2'd0;
    w_any = |w_miss;
    for (int k = 3; k >= 0; k--) begin
      w_sel = w_miss[k] ? 2'(k) : w_sel;
    end
  end
`endif

  // Transaction FSM and cache fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_win    <= 2'd0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      r_valid  <= 4'b0000;
      r_tag    <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            rom_cs   <= 1'b1;
            rom_addr <= req_addr[w_sel*AW +: AW];
            r_win    <= w_sel;
            r_state  <= ST_REQ;
          end else begin
            rom_cs   <= 1'b0;
          end
        end
        // rom_ok may still be high from the previous access, so it is ignored here
        ST_REQ: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (rom_ok) begin
            r_data[r_win]  <= rom_data;
            r_tag[r_win]   <= rom_addr;
            r_valid[r_win] <= 1'b1;
            rom_cs         <= 1'b0;
            r_state        <= ST_IDLE;
          end else begin
            rom_cs         <= 1'b1;
          end
        end
        default: begin
          rom_cs  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtsbaskt_romarb.sv
// Directed self-checking bench for jtsbaskt_romarb (works with or without JTSBASKT_RR_EN).
`timescale 1ns/1ps
module tb_jtsbaskt_romarb;
  localparam int AW = 22;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_cs;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ok;
  logic            rom_cs;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic            rom_ok;

  int n_cmp = 0;
  int n_err = 0;

  jtsbaskt_romarb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_cs(req_cs), .req_addr(req_addr),
    .req_data(req_data), .req_ok(req_ok), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven 2 ns after the edge, checks 1 ns later
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_cs   = 4'b0000;
    req_addr = '0;
    rom_ok   = 1'b0;
    rom_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req_cs   = 4'b1111;
    req_addr = '0;
    rom_ok   = 1'b0;
    rom_data = 8'h00;
    #3;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
    n_cmp++; if (rom_addr !== 22'h0) begin n_err++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    n_cmp++; if (req_ok !== 4'b0000) begin n_err++; $display("FAIL reset_req_ok: got %b want 0000", req_ok); end
    n_cmp++; if (req_data !== 32'h0) begin n_err++; $display("FAIL reset_req_data: got %h want 0", req_data); end
    do_reset();
  endtask

  task automatic test_single_miss();
    req_cs = 4'b0001;
    set_addr(0, 22'h000100);
    #1;
    n_cmp++; if (req_ok !== 4'b0000) begin n_err++; $display("FAIL single_c0_ok: got %b want 0000", req_ok); end
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL single_c0_cs: got %b want 0", rom_cs); end
    cyc(); #1;
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL single_c1_cs: got %b want 1", rom_cs); end
    n_cmp++; if (rom_addr !== 22'h000100) begin n_err++; $display("FAIL single_c1_addr: got %h want 000100", rom_addr); end
    cyc();
    rom_ok = 1'b1; rom_data = 8'h5A;
    #1;
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL single_c2_cs: got %b want 1", rom_cs); end
    n_cmp++; if (req_ok !== 4'b0000) begin n_err++; $display("FAIL single_c2_ok: got %b want 0000", req_ok); end
    cyc();
    rom_ok = 1'b0; rom_data = 8'h00;
    #1;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL single_c3_cs: got %b want 0", rom_cs); end
    n_cmp++; if (req_ok !== 4'b0001) begin n_err++; $display("FAIL single_c3_ok: got %b want 0001", req_ok); end
    n_cmp++; if (req_data[7:0] !== 8'h5A) begin n_err++; $display("FAIL single_c3_data: got %h want 5a", req_data[7:0]); end
    for (int c = 0; c < 3; c++) begin
      cyc(); #1;
      n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL repeat_cs[%0d]: got %b want 0", c, rom_cs); end
      n_cmp++; if (req_ok !== 4'b0001) begin n_err++; $display("FAIL repeat_ok[%0d]: got %b want 0001", c, req_ok); end
    end
  endtask

  task automatic test_priority();
    do_reset();
    req_cs = 4'b0101;
    set_addr(0, 22'h000111);
    set_addr(2, 22'h000222);
    cyc(); #1;
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL prio_t1_cs: got %b want 1", rom_cs); end
    n_cmp++; if (rom_addr !== 22'h000111) begin n_err++; $display("FAIL prio_t1_addr: got %h want 000111", rom_addr); end
    cyc();
    rom_ok = 1'b1; rom_data = 8'hA1;
    cyc();
    rom_ok = 1'b0;
    #1;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL prio_gap_cs: got %b want 0", rom_cs); end
    n_cmp++; if (req_ok !== 4'b0001) begin n_err++; $display("FAIL prio_gap_ok: got %b want 0001", req_ok); end
    cyc(); #1;
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL prio_t2_cs: got %b want 1", rom_cs); end
    n_cmp++; if (rom_addr !== 22'h000222) begin n_err++; $display("FAIL prio_t2_addr: got %h want 000222", rom_addr); end
    cyc();
    rom_ok = 1'b1; rom_data = 8'hA2;
    cyc();
    rom_ok = 1'b0;
    #1;
    n_cmp++; if (req_ok !== 4'b0101) begin n_err++; $display("FAIL prio_end_ok: got %b want 0101", req_ok); end
    n_cmp++; if (req_data[23:16] !== 8'hA2) begin n_err++; $display("FAIL prio_end_data2: got %h want a2", req_data[23:16]); end
    n_cmp++; if (req_data[7:0] !== 8'hA1) begin n_err++; $display("FAIL prio_end_data0: got %h want a1", req_data[7:0]); end
    n_cmp++; if (rom_addr !== 22'h000222) begin n_err++; $display("FAIL prio_addr_hold: got %h want 000222", rom_addr); end
  endtask

  task automatic test_rotation();
    logic [AW-1:0] exp_a [4];
    logic [7:0]    exp_d0;
`ifdef JTSBASKT_RR_EN
    exp_a[0] = 22'h10; exp_a[1] = 22'h20; exp_a[2] = 22'h30; exp_a[3] = 22'h11;
    exp_d0 = 8'h13;
`else
    exp_a[0] = 22'h10; exp_a[1] = 22'h11; exp_a[2] = 22'h20; exp_a[3] = 22'h30;
    exp_d0 = 8'h11;
`endif
    do_reset();
    req_cs = 4'b1101;
    set_addr(0, 22'h10);
    set_addr(2, 22'h20);
    set_addr(3, 22'h30);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL rot_cs[%0d]: got %b want 1", k, rom_cs); end
      n_cmp++; if (rom_addr !== exp_a[k]) begin n_err++; $display("FAIL rot_addr[%0d]: got %h want %h", k, rom_addr, exp_a[k]); end
      cyc();
      rom_ok = 1'b1; rom_data = 8'h10 + 8'(k);
      if (k == 0) set_addr(0, 22'h11);
      cyc();
      rom_ok = 1'b0;
      #1;
      n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL rot_gap[%0d]: got %b want 0", k, rom_cs); end
    end
    n_cmp++; if (req_ok !== 4'b1101) begin n_err++; $display("FAIL rot_end_ok: got %b want 1101", req_ok); end
    n_cmp++; if (req_data[7:0] !== exp_d0) begin n_err++; $display("FAIL rot_end_data0: got %h want %h", req_data[7:0], exp_d0); end
  endtask

  task automatic test_ok_held();
    do_reset();
    rom_ok = 1'b1; rom_data = 8'hEE;
    req_cs = 4'b0001;
    set_addr(0, 22'h000300);
    cyc(); #1;
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL held_req_cs: got %b want 1", rom_cs); end
    rom_ok = 1'b0;
    cyc(); #1;
    n_cmp++; if (req_ok !== 4'b0000) begin n_err++; $display("FAIL held_no_fill_in_req: got %b want 0000", req_ok); end
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL held_wait1_cs: got %b want 1", rom_cs); end
    cyc(); #1;
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL held_wait2_cs: got %b want 1", rom_cs); end
    n_cmp++; if (req_ok !== 4'b0000) begin n_err++; $display("FAIL held_wait2_ok: got %b want 0000", req_ok); end
    rom_ok = 1'b1; rom_data = 8'h77;
    cyc();
    rom_ok = 1'b0;
    #1;
    n_cmp++; if (req_ok !== 4'b0001) begin n_err++; $display("FAIL held_fill_ok: got %b want 0001", req_ok); end
    n_cmp++; if (req_data[7:0] !== 8'h77) begin n_err++; $display("FAIL held_fill_data: got %h want 77", req_data[7:0]); end
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL held_idle_cs: got %b want 0", rom_cs); end
  endtask

  task automatic test_addr_change();
    req_cs = 4'b0010;
    set_addr(1, 22'h002000);
    cyc();
    cyc();
    set_addr(1, 22'h002001);
    rom_ok = 1'b1; rom_data = 8'h21;
    cyc();
    rom_ok = 1'b0;
    #1;
    n_cmp++; if (req_ok[1] !== 1'b0) begin n_err++; $display("FAIL achg_ok_new_addr: got %b want 0", req_ok[1]); end
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL achg_idle_cs: got %b want 0", rom_cs); end
    set_addr(1, 22'h002000);
    #1;
    n_cmp++; if (req_ok[1] !== 1'b1) begin n_err++; $display("FAIL achg_tag_old: got %b want 1", req_ok[1]); end
    n_cmp++; if (req_data[15:8] !== 8'h21) begin n_err++; $display("FAIL achg_data_old: got %h want 21", req_data[15:8]); end
    set_addr(1, 22'h002001);
    cyc(); #1;
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL achg_t2_cs: got %b want 1", rom_cs); end
    n_cmp++; if (rom_addr !== 22'h002001) begin n_err++; $display("FAIL achg_t2_addr: got %h want 002001", rom_addr); end
    cyc();
    rom_ok = 1'b1; rom_data = 8'h22;
    cyc();
    rom_ok = 1'b0;
    #1;
    n_cmp++; if (req_ok !== 4'b0010) begin n_err++; $display("FAIL achg_t2_ok: got %b want 0010", req_ok); end
    n_cmp++; if (req_data[15:8] !== 8'h22) begin n_err++; $display("FAIL achg_t2_data: got %h want 22", req_data[15:8]); end
  endtask

  task automatic test_cs_drop();
    req_cs = 4'b1000;
    set_addr(3, 22'h003ABC);
    cyc(); #1;
    n_cmp++; if (rom_addr !== 22'h003ABC) begin n_err++; $display("FAIL drop_addr: got %h want 003abc", rom_addr); end
    req_cs = 4'b0000;
    cyc();
    rom_ok = 1'b1; rom_data = 8'h3C;
    cyc();
    rom_ok = 1'b0;
    #1;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL drop_done_cs: got %b want 0", rom_cs); end
    n_cmp++; if (req_ok !== 4'b0000) begin n_err++; $display("FAIL drop_no_cs_ok: got %b want 0000", req_ok); end
    req_cs = 4'b1000;
    #1;
    n_cmp++; if (req_ok !== 4'b1000) begin n_err++; $display("FAIL drop_reassert_ok: got %b want 1000", req_ok); end
    n_cmp++; if (req_data[31:24] !== 8'h3C) begin n_err++; $display("FAIL drop_data: got %h want 3c", req_data[31:24]); end
    cyc(); #1;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL drop_no_new_req: got %b want 0", rom_cs); end
  endtask

  task automatic test_reset_mid();
    req_cs = 4'b1001;
    set_addr(0, 22'h000400);
    cyc();
    cyc(); #1;
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL rmid_wait_cs: got %b want 1", rom_cs); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rom_cs !== 1'b0) begin n_err++; $display("FAIL rmid_async_cs: got %b want 0", rom_cs); end
    n_cmp++; if (req_ok !== 4'b0000) begin n_err++; $display("FAIL rmid_async_ok: got %b want 0000", req_ok); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(); #1;
    n_cmp++; if (req_ok !== 4'b0000) begin n_err++; $display("FAIL rmid_remiss_ok: got %b want 0000", req_ok); end
    n_cmp++; if (rom_cs !== 1'b1) begin n_err++; $display("FAIL rmid_remiss_cs: got %b want 1", rom_cs); end
    n_cmp++; if (rom_addr !== 22'h000400) begin n_err++; $display("FAIL rmid_remiss_addr: got %h want 000400", rom_addr); end
    cyc();
    rom_ok = 1'b1; rom_data = 8'h44;
    cyc();
    rom_ok = 1'b0;
    #1;
    n_cmp++; if (req_ok !== 4'b0001) begin n_err++; $display("FAIL rmid_refill_ok: got %b want 0001", req_ok); end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_priority();
    test_rotation();
    test_ok_held();
    test_addr_change();
    test_cs_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
